// File: rtl/dmem_lanes.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lanes
// Brief    : Byte-lane banked data memory with sub-word load/store, sign/zero
//            extension, error flagging and an optional post-reset clear.
// Revision : 1.0
// ============================================================================
module dmem_lanes #(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 16384,
  parameter string FILENAME       = "",
  parameter bit    CLEAR_ON_RESET = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_req_valid,
  output logic                                   o_req_ready,
  input  logic                                   i_req_we,
  input  logic [$clog2(DEPTH*(DATA_W/8))-1:0]    i_req_addr,
  input  logic [1:0]                             i_req_size,
  input  logic                                   i_req_unsigned,
  input  logic [DATA_W-1:0]                      i_req_wdata,
  output logic                                   o_rsp_valid,
  output logic [DATA_W-1:0]                      o_rsp_rdata,
  output logic                                   o_rsp_err,
  output logic                                   o_busy
);

  localparam int c_nb     = DATA_W / 8;
  localparam int c_log_nb = (c_nb > 1) ? $clog2(c_nb) : 0;
  localparam int c_addr_w = $clog2(DEPTH * c_nb);
  localparam int c_cnt_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_addr_w-1:0] c_depth = c_addr_w'(DEPTH);
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DEPTH - 1);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_ready;
  logic                 r_busy;

  logic [c_addr_w-1:0]  w_word_full;
  logic [c_cnt_w-1:0]   w_word;
  logic [3:0]           w_off;
  logic [3:0]           w_nbytes;
  logic                 w_err;
  logic                 w_acc;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_clr;
  logic [DATA_W-1:0]    w_wsh;
  logic [DATA_W-1:0]    w_rdata;

  assign w_word_full = i_req_addr >> c_log_nb;
  assign w_word      = w_word_full[c_cnt_w-1:0];
  assign w_nbytes    = 4'd1 << i_req_size;

  if (c_nb > 1) begin : g_off
    assign w_off = 4'(i_req_addr[c_log_nb-1:0]);
  end else begin : g_off_none
    assign w_off = 4'd0;
  end

  assign w_err = ((w_off & (w_nbytes - 4'd1)) != 4'd0) ||
                 (w_nbytes > 4'(c_nb)) ||
                 (w_word_full >= c_depth);
  // A request seen on a reset edge is neither performed nor answered.
  assign w_acc = i_req_valid & r_ready & ~rst;
  assign w_wr  = w_acc & i_req_we & ~w_err;
  assign w_rd  = w_acc & ~i_req_we & ~w_err;
  assign w_clr = (r_state == S_CLEAR);
  assign w_wsh = i_req_wdata << {w_off, 3'b000};

  for (genvar i = 0; i < c_nb; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;
    logic       w_en;

    assign w_en = w_wr && (4'(i) >= w_off) && (4'(i) < w_off + w_nbytes);

    always_ff @(posedge clk) begin
      if (w_clr) begin
        r_mem[r_cnt] <= 8'h00;
      end else if (w_en) begin
        r_mem[w_word] <= w_wsh[8*i +: 8];
      end
      if (w_rd) begin
        r_q <= r_mem[w_word];
      end
    end

    assign w_rdata[8*i +: 8] = r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_cnt   <= '0;
      r_ready <= ~CLEAR_ON_RESET;
      r_busy  <= CLEAR_ON_RESET;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_busy      = r_busy;

  logic       r_valid;
  logic       r_err;
  logic       r_load;
  logic       r_uns;
  logic [3:0] r_off;
  logic [3:0] r_nbytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_load   <= 1'b0;
      r_uns    <= 1'b0;
      r_off    <= 4'd0;
      r_nbytes <= 4'd0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_err    <= w_err;
        r_load   <= ~i_req_we;
        r_uns    <= i_req_unsigned;
        r_off    <= w_off;
        r_nbytes <= w_nbytes;
      end
    end
  end

  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_ld;
  logic              w_sign;

  // Sub-word is shifted to bit 0; bytes above it take the fill value.
  always_comb begin
    w_ext  = w_rdata >> {r_off, 3'b000};
    w_sign = 1'b0;
    w_ld   = '0;
    for (int b = 0; b < c_nb; b++) begin
      if (4'(b) == r_nbytes - 4'd1) w_sign = w_ext[8*b+7];
    end
    for (int b = 0; b < c_nb; b++) begin
      w_ld[8*b +: 8] = (4'(b) < r_nbytes) ? w_ext[8*b +: 8] : {8{w_sign & ~r_uns}};
    end
  end

  assign o_rsp_valid = r_valid;
  assign o_rsp_err   = r_valid & r_err;
  assign o_rsp_rdata = (r_valid & ~r_err & r_load) ? w_ld : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lanes.sv
`default_nettype none
// Bench for dmem_lanes: a clearing 16-word instance (A) and a non-clearing
// 12-word instance (B) share stimulus and are checked against a byte model.
module tb_dmem_lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_uns = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;

  logic        rdy_a, vld_a, err_a, busy_a;
  logic [31:0] rd_a;
  logic        rdy_b, vld_b, err_b, busy_b;
  logic [31:0] rd_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mdl [2][64];
  int          dep [2] = '{16, 12};
  bit          exp_err [2];
  logic [31:0] exp_rd [2];
  bit          acc [2];

  always #5 clk = ~clk;

  dmem_lanes #(.DATA_W(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy_a),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_unsigned(req_uns), .i_req_wdata(req_wdata), .o_rsp_valid(vld_a),
    .o_rsp_rdata(rd_a), .o_rsp_err(err_a), .o_busy(busy_a)
  );

  dmem_lanes #(.DATA_W(32), .DEPTH(12), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy_b),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_unsigned(req_uns), .i_req_wdata(req_wdata), .o_rsp_valid(vld_b),
    .o_rsp_rdata(rd_b), .o_rsp_err(err_b), .o_busy(busy_b)
  );

  // Byte-array reference: computes the expected response and applies stores.
  task automatic model_req(input int d, input bit we, input int addr, input int size,
                           input bit uns, input logic [31:0] wd);
    int nb;
    logic [63:0] v;
    nb = 1 << size;
    v  = '0;
    exp_err[d] = (addr % nb != 0) || (nb > 4) || (addr / 4 >= dep[d]);
    exp_rd[d]  = '0;
    if (!exp_err[d]) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mdl[d][addr+k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) v = v | (64'(mdl[d][addr+k]) << (8*k));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        exp_rd[d] = v[31:0];
      end
    end
  endtask

  // Called at a negedge; returns at the next negedge with the response visible.
  task automatic issue(input bit we, input int addr, input int size, input bit uns,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = 6'(addr);
    req_size  = 2'(size);
    req_uns   = uns;
    req_wdata = wd;
    acc[0]    = rdy_a;
    acc[1]    = rdy_b;
    @(posedge clk);
    if (acc[0] && !rst) model_req(0, we, addr, size, uns, wd);
    if (acc[1] && !rst) model_req(1, we, addr, size, uns, wd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int  cyc;
    bit  bad_rdy;
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (vld_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0 || vld_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: got vld_a=%b rd_a=%h err_a=%b vld_b=%b, want 0 0 0 0",
               vld_a, rd_a, err_a, vld_b);
    end
    n_checks++;
    if (busy_a !== 1'b1 || rdy_a !== 1'b0 || busy_b !== 1'b0 || rdy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got busy_a=%b rdy_a=%b busy_b=%b rdy_b=%b, want 1 0 0 1",
               busy_a, rdy_a, busy_b, rdy_b);
    end
    rst = 1'b0;
    cyc = 0;
    bad_rdy = 1'b0;
    while (busy_a === 1'b1 && cyc < 100) begin
      if (rdy_a !== 1'b0) bad_rdy = 1'b1;
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc != 16 || bad_rdy || rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_len: got busy cycles=%0d ready_during_busy=%b rdy_after=%b, want 16 0 1",
               cyc, bad_rdy, rdy_a);
    end
    for (int i = 0; i < 64; i++) mdl[0][i] = 8'h00;
  endtask

  task automatic test_clear_zero();
    for (int w = 0; w < 16; w++) begin
      issue(1'b0, 4*w, 2, 1'b0, 32'h0);
      n_checks++;
      if (vld_a !== 1'b1 || err_a !== 1'b0 || rd_a !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_zero word %0d: got vld=%b err=%b rd=%h, want 1 0 00000000",
                 w, vld_a, err_a, rd_a);
      end
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < 16; w++) begin
      issue(1'b1, 4*w, 2, 1'b0, $urandom);
      n_checks++;
      if (vld_a !== 1'b1 || err_a !== 1'b0 || rd_a !== 32'h0 ||
          vld_b !== 1'b1 || err_b !== (w >= 12) || rd_b !== 32'h0) begin
        n_fail++;
        $display("FAIL fill word %0d: got A(%b %b %h) B(%b %b %h), want A(1 0 0) B(1 %b 0)",
                 w, vld_a, err_a, rd_a, vld_b, err_b, rd_b, (w >= 12));
      end
    end
  endtask

  task automatic test_subword();
    int          ta [4] = '{'h13, 'h13, 'h10, 'h10};
    int          ts [4] = '{0, 0, 1, 2};
    bit          tu [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'hDEADBEEF};
    issue(1'b1, 'h10, 2, 1'b0, 32'hDEADBEEF);
    n_checks++;
    if (vld_a !== 1'b1 || err_a !== 1'b0 || rd_a !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_ack: got vld=%b err=%b rd=%h, want 1 0 00000000", vld_a, err_a, rd_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (vld_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_zero %0d: got vld=%b rd=%h err=%b, want 0 0 0", i, vld_a, rd_a, err_a);
      end
      issue(1'b0, ta[i], ts[i], tu[i], 32'h0);
      n_checks++;
      if (vld_a !== 1'b1 || err_a !== 1'b0 || rd_a !== te[i] || rd_b !== te[i]) begin
        n_fail++;
        $display("FAIL subword %0d: got vld=%b err=%b rd_a=%h rd_b=%h, want 1 0 %h",
                 i, vld_a, err_a, rd_a, rd_b, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 'h11, 0, 1'b0, 32'h00000055);
    n_checks++;
    if (vld_a !== 1'b1 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_sb: got vld=%b err=%b, want 1 0", vld_a, err_a);
    end
    issue(1'b0, 'h10, 2, 1'b0, 32'h0);
    n_checks++;
    if (vld_a !== 1'b1 || rd_a !== 32'hDEAD55EF) begin
      n_fail++;
      $display("FAIL b2b_lw: got vld=%b rd=%h, want 1 DEAD55EF", vld_a, rd_a);
    end
  endtask

  task automatic test_misaligned();
    bit          tw [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int          ta [5] = '{'h13, 'h10, 'h12, 'h10, 'h10};
    int          ts [5] = '{1, 2, 2, 3, 3};
    bit          te [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] tr [5] = '{32'h0, 32'hDEAD55EF, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      issue(tw[i], ta[i], ts[i], 1'b0, 32'h12345678);
      n_checks++;
      if (vld_a !== 1'b1 || err_a !== te[i] || rd_a !== tr[i]) begin
        n_fail++;
        $display("FAIL misaligned %0d: got vld=%b err=%b rd=%h, want 1 %b %h",
                 i, vld_a, err_a, rd_a, te[i], tr[i]);
      end
    end
    issue(1'b0, 'h10, 2, 1'b0, 32'h0);
    n_checks++;
    if (rd_a !== 32'hDEAD55EF) begin
      n_fail++;
      $display("FAIL err_nowrite: got rd=%h, want DEAD55EF", rd_a);
    end
  endtask

  task automatic test_range();
    issue(1'b0, 48, 2, 1'b0, 32'h0);
    n_checks++;
    if (vld_b !== 1'b1 || err_b !== 1'b1 || rd_b !== 32'h0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL range_48: got B(vld=%b err=%b rd=%h) err_a=%b, want B(1 1 0) 0",
               vld_b, err_b, rd_b, err_a);
    end
    issue(1'b0, 44, 2, 1'b0, 32'h0);
    n_checks++;
    if (vld_b !== 1'b1 || err_b !== 1'b0 || rd_b !== exp_rd[1]) begin
      n_fail++;
      $display("FAIL range_44: got vld=%b err=%b rd=%h, want 1 0 %h", vld_b, err_b, rd_b, exp_rd[1]);
    end
  endtask

  task automatic test_random();
    int sz, ad;
    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      ad = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0 && sz < 3) ad = ad & ~((1 << sz) - 1);
      issue(1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom);
      n_checks++;
      if (vld_a !== 1'b1 || err_a !== exp_err[0] || rd_a !== exp_rd[0]) begin
        n_fail++;
        $display("FAIL rand_a %0d addr=%0d size=%0d: got vld=%b err=%b rd=%h, want 1 %b %h",
                 n, ad, sz, vld_a, err_a, rd_a, exp_err[0], exp_rd[0]);
      end
      n_checks++;
      if (vld_b !== 1'b1 || err_b !== exp_err[1] || rd_b !== exp_rd[1]) begin
        n_fail++;
        $display("FAIL rand_b %0d addr=%0d size=%0d: got vld=%b err=%b rd=%h, want 1 %b %h",
                 n, ad, sz, vld_b, err_b, rd_b, exp_err[1], exp_rd[1]);
      end
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        n_checks++;
        if (vld_a !== 1'b0 || vld_b !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_idle %0d: got vld_a=%b vld_b=%b, want 0 0", n, vld_a, vld_b);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    issue(1'b0, 'h10, 2, 1'b0, 32'h0);
    n_checks++;
    if (vld_a !== 1'b1 || rd_a !== exp_rd[0]) begin
      n_fail++;
      $display("FAIL pre_reset_lw: got vld=%b rd=%h, want 1 %h", vld_a, rd_a, exp_rd[0]);
    end
    rst = 1'b1;
    issue(1'b0, 'h14, 2, 1'b0, 32'h0);
    n_checks++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || rd_b !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drop: got vld_a=%b vld_b=%b rd_b=%h, want 0 0 0", vld_a, vld_b, rd_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mdl[0][i] = 8'h00;
    issue(1'b0, 'h10, 2, 1'b0, 32'h0);
    n_checks++;
    if (vld_a !== 1'b0 || vld_b !== 1'b1 || rd_b !== exp_rd[1]) begin
      n_fail++;
      $display("FAIL reset_keep: got vld_a=%b vld_b=%b rd_b=%h, want 0 1 %h",
               vld_a, vld_b, rd_b, exp_rd[1]);
    end
    cyc = 0;
    while (busy_a === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reclear_done: got busy=%b rdy=%b after %0d cycles, want 0 1", busy_a, rdy_a, cyc);
    end
    for (int w = 0; w < 12; w++) begin
      issue(1'b0, 4*w, 2, 1'b1, 32'h0);
      n_checks++;
      if (vld_a !== 1'b1 || rd_a !== 32'h0 || vld_b !== 1'b1 || rd_b !== exp_rd[1]) begin
        n_fail++;
        $display("FAIL post_reset word %0d: got A(%b %h) B(%b %h), want A(1 0) B(1 %h)",
                 w, vld_a, rd_a, vld_b, rd_b, exp_rd[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_fill();
    test_subword();
    test_back_to_back();
    test_misaligned();
    test_range();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
